uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter with a one-entry holding buffer.
// Frame: start bit (0), DATA_BITS data bits LSB first, stop bit(s), no parity.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_sample_tick  one-clock pulse at 16x the baud rate
//   i_start        send request, taken only while o_ready=1
//   i_data         byte to send, sampled in the accept cycle
//   o_ready        holding buffer empty
//   o_tx           serial line, idle high, driven from a flop
//   o_tx_busy      FSM is outside S_IDLE
//   o_tx_done_tick one-clock pulse on the last tick of the stop bit
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_TICK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sample_tick,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done_tick
);

    // Tick counter must reach both the 16-tick bit period and the stop length.
    localparam int TICK_MAX = (STOP_TICK - 1 > 15) ? STOP_TICK - 1 : 15;
    localparam int TW = $clog2(TICK_MAX + 1);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_BIT_END  = TW'(15);
    localparam logic [TW-1:0] TICK_STOP_END = TW'(STOP_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   accept;
    logic                   done_tick;

    assign accept = i_start & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        done_tick  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A fresh accept bypasses the buffer; a waiting byte
                // is drained only when no accept is possible (buffer full).
                if (accept) begin
                    shreg_d = i_data;
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                end else if (buf_full_q) begin
                    shreg_d    = buf_q;
                    buf_d      = '0;
                    buf_full_d = 1'b0;
                    state_d    = S_START;
                    tick_d     = '0;
                    bit_d      = '0;
                end
            end

            S_START: begin
                if (i_sample_tick) begin
                    if (tick_q == TICK_BIT_END) begin
                        state_d = S_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (i_sample_tick) begin
                    if (tick_q == TICK_BIT_END) begin
                        tick_d  = '0;
                        shreg_d = shreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (i_sample_tick) begin
                    if (tick_q == TICK_STOP_END) begin
                        done_tick = 1'b1;
                        state_d   = S_IDLE;
                        tick_d    = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Outside S_IDLE an accepted byte always lands in the buffer,
        // including the done-tick clock (state is still S_STOP then).
        if (accept && (state_q != S_IDLE)) begin
            buf_d      = i_data;
            buf_full_d = 1'b1;
        end
    end

    // Line level follows the next state, so o_tx changes on the same
    // edge as the state and comes straight out of a flop.
    always_comb begin
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_ready        = ~buf_full_q;
    assign o_tx_busy      = busy_q;
    // Pulses in the clock whose edge ends the stop bit.
    assign o_tx_done_tick = done_tick;

endmodule
